// File: rtl/map_line_builder_if.sv
// Bus bundle between the scanline builder, its requester and the map ROM.
//
// Request handshake: the requester raises line_req with line_y valid in the
// same cycle. The request is taken on a rising clock edge only while busy is
// low; a request seen while busy is high is dropped, never queued. busy stays
// high from the accepting edge until the edge that raises line_valid, which is
// a one-cycle pulse. line_data is stable at all other times.
//
// ROM port: rom_addr is registered by the builder; the ROM registers it and
// presents rom_data one clock later.
interface map_line_builder_if #(
    parameter int LINE_PIX = 848,
    parameter int MAP_W    = 106,
    parameter int AW       = 6
);
    logic                    line_req;
    logic [8:0]              line_y;
    logic                    busy;
    logic                    line_valid;
    logic [2*LINE_PIX-1:0]   line_data;
    logic [AW-1:0]           rom_addr;
    logic [2*MAP_W-1:0]      rom_data;

    // Requester plus ROM side
    modport master (
        output line_req,
        output line_y,
        output rom_data,
        input  busy,
        input  line_valid,
        input  line_data,
        input  rom_addr
    );

    // Builder side
    modport slave (
        input  line_req,
        input  line_y,
        input  rom_data,
        output busy,
        output line_valid,
        output line_data,
        output rom_addr
    );
endinterface

// File: rtl/map_line_builder.sv
// Expands one coarse map row (2 bits per cell) into a packed 2-bit/pixel
// scanline by replicating each cell CELL times horizontally. The row is
// fetched from a synchronous ROM and expanded CHUNK cells per clock.
module map_line_builder #(
    parameter int LINE_PIX = 848,
    parameter int CELL     = 8,
    parameter int MAP_W    = 106,
    parameter int MAP_H    = 60,
    parameter int AW       = 6,
    parameter int CHUNK    = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    map_line_builder_if.slave    bus,
    output logic [2:0]           dbg_state_o
);

    localparam int CELL_LG = $clog2(CELL);
    localparam int NCHUNK  = MAP_W / CHUNK;
    localparam int KW      = (NCHUNK > 1) ? $clog2(NCHUNK + 1) : 1;
    localparam int LW      = 2 * LINE_PIX;
    localparam int SW      = 2 * MAP_W;
    localparam int CW      = 2 * CHUNK * CELL;

    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
    localparam logic [8:0]    ROW_LIM = 9'(MAP_H);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_EXPAND = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]     state_q,    state_d;
    logic           oob_q,      oob_d;
    logic           busy_q,     busy_d;
    logic           valid_q,    valid_d;
    logic [AW-1:0]  rom_addr_q, rom_addr_d;
    logic [KW-1:0]  k_q,        k_d;
    logic [SW-1:0]  src_q,      src_d;
    logic [LW-1:0]  work_q,     work_d;
    logic [LW-1:0]  line_q,     line_d;

    logic [8:0]     row;
    logic [CW-1:0]  chunk_pix;

    // Map row addressed by the requested pixel row
    assign row = bus.line_y >> CELL_LG;

    // Replicate the lowest CHUNK cells of the source shift register; cell i
    // of the chunk lands in the lower pixels so chunks read left to right.
    always_comb begin
        chunk_pix = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pix[i*2*CELL +: 2*CELL] = {CELL{src_q[2*i +: 2]}};
        end
    end

    // Next-state logic. The work register is filled by shifting expanded
    // chunks in from the top; after NCHUNK shifts the first chunk has reached
    // pixel 0, so each cell ends up at pixels c*CELL .. c*CELL+CELL-1.
    always_comb begin
        state_d    = state_q;
        oob_d      = oob_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        rom_addr_d = rom_addr_q;
        k_d        = k_q;
        src_d      = src_q;
        work_d     = work_q;
        line_d     = line_q;

        case (state_q)
            S_IDLE: begin
                if (bus.line_req) begin
                    busy_d = 1'b1;
                    if (row < ROW_LIM) begin
                        rom_addr_d = row[AW-1:0];
                        oob_d      = 1'b0;
                    end else begin
                        oob_d      = 1'b1;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                src_d   = oob_q ? '0 : bus.rom_data;
                k_d     = '0;
                state_d = S_EXPAND;
            end
            S_EXPAND: begin
                work_d = {chunk_pix, work_q[LW-1:CW]};
                src_d  = src_q >> (2 * CHUNK);
                k_d    = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                line_d  = work_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any build in progress
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            oob_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            rom_addr_q <= '0;
            k_q        <= '0;
            src_q      <= '0;
            work_q     <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            oob_q      <= oob_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            rom_addr_q <= rom_addr_d;
            k_q        <= k_d;
            src_q      <= src_d;
            work_q     <= work_d;
            line_q     <= line_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.line_valid = valid_q;
    assign bus.line_data  = line_q;
    assign bus.rom_addr   = rom_addr_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_map_line_builder.sv
// Directed bench for map_line_builder with a behavioural synchronous map ROM.
module tb_map_line_builder;
    localparam int LINE_PIX = 848;
    localparam int CELL     = 8;
    localparam int MAP_W    = 106;
    localparam int MAP_H    = 60;
    localparam int AW       = 6;
    localparam int CHUNK    = 2;
    localparam int LW       = 2 * LINE_PIX;
    localparam int SW       = 2 * MAP_W;
    localparam int LAT      = 56;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;

    logic [SW-1:0] rom [MAP_H];
    logic [SW-1:0] row0, row3, row59;
    logic [LW-1:0] zero_line;

    logic [AW-1:0] addr1;
    int            first_v, nvalid, nbusy, dev;

    // clock / reset
    always #5 clk = ~clk;

    map_line_builder_if #(.LINE_PIX(LINE_PIX), .MAP_W(MAP_W), .AW(AW)) bus ();

    map_line_builder #(
        .LINE_PIX(LINE_PIX), .CELL(CELL), .MAP_W(MAP_W),
        .MAP_H(MAP_H), .AW(AW), .CHUNK(CHUNK)
    ) dut (
        .CLK(clk),
        .reset(rst_n),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    // synchronous map ROM: data one clock after the address
    always_ff @(posedge clk) begin
        if (int'(bus.rom_addr) < MAP_H) bus.rom_data <= rom[int'(bus.rom_addr)];
        else                            bus.rom_data <= '0;
    end

    function automatic logic [LW-1:0] expand(input logic [SW-1:0] cells);
        logic [LW-1:0] r;
        r = '0;
        for (int p = 0; p < LINE_PIX; p++) r[2*p +: 2] = cells[2*(p/CELL) +: 2];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [LW-1:0] exp);
        int bad;
        int first;
        int fp;
        bad = 0;
        first = -1;
        for (int p = 0; p < LINE_PIX; p++) begin
            if (bus.line_data[2*p +: 2] !== exp[2*p +: 2]) begin
                bad++;
                if (first < 0) first = p;
            end
        end
        fp = (first < 0) ? 0 : first;
        checks++;
        assert (bus.line_data === exp) else begin
            errors++;
            $error("FAIL %s: %0d pixels differ, first pixel %0d observed %0d expected %0d",
                   tag, bad, fp, bus.line_data[2*fp +: 2], exp[2*fp +: 2]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_valid"}, 32'(bus.line_valid), 32'd0);
        check({tag, "_addr"},  32'(bus.rom_addr), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        check_line({tag, "_data"}, zero_line);
    endtask

    // driver: issue one request and observe a fixed 70-clock window
    task automatic run_build(input logic [8:0] y, input int inj_at, input logic [8:0] inj_y,
                             input int rst_at, output logic [AW-1:0] a1,
                             output int fv, output int nv, output int nb);
        bus.line_y   = y;
        bus.line_req = 1'b1;
        @(posedge clk); #1;
        bus.line_req = 1'b0;
        a1 = bus.rom_addr;
        nb = (bus.busy === 1'b1) ? 1 : 0;
        fv = -1;
        nv = 0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            bus.line_req = 1'b0;
            if (bus.busy === 1'b1) nb++;
            if (bus.line_valid === 1'b1) begin
                nv++;
                if (fv < 0) fv = n;
            end
            if (n == inj_at) begin
                bus.line_y   = inj_y;
                bus.line_req = 1'b1;
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
            end
            if (n == rst_at + 2) rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.line_req = 1'b0;
        bus.line_y   = '0;
        zero_line    = '0;

        row0 = '0;
        row0[1:0]     = 2'd1;
        row0[3:2]     = 2'd3;
        row0[211:210] = 2'd2;
        for (int c = 0; c < MAP_W; c++) row3[2*c +: 2] = 2'd2;
        for (int c = 0; c < MAP_W; c++) row59[2*c +: 2] = 2'(c % 4);
        for (int r = 0; r < MAP_H; r++) rom[r] = '0;
        rom[0]  = row0;
        rom[3]  = row3;
        rom[59] = row59;

        // reset, then idle
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        dev = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.line_valid !== 1'b0 || bus.rom_addr !== '0 ||
                bus.line_data !== zero_line || dbg_state !== 3'd0) dev++;
        end
        check("idle_stable", 32'(dev), 32'd0);

        // row 3, all cells green
        run_build(9'd29, -1, 9'd0, -1, addr1, first_v, nvalid, nbusy);
        check("row3_addr",  32'(addr1), 32'd3);
        check("row3_lat",   32'(first_v), 32'(LAT));
        check("row3_npulse", 32'(nvalid), 32'd1);
        check("row3_busy",  32'(nbusy), 32'(LAT));
        check_line("row3_data", expand(row3));
        check("row3_idle",  32'(bus.busy), 32'd0);

        // row 0 with edge cells
        run_build(9'd0, -1, 9'd0, -1, addr1, first_v, nvalid, nbusy);
        check("row0_addr", 32'(addr1), 32'd0);
        check("row0_lat",  32'(first_v), 32'(LAT));
        check_line("row0_data", expand(row0));

        // last map row
        run_build(9'd479, -1, 9'd0, -1, addr1, first_v, nvalid, nbusy);
        check("row59_addr", 32'(addr1), 32'd59);
        check("row59_lat",  32'(first_v), 32'(LAT));
        check_line("row59_data", expand(row59));

        // out-of-range row: black, same latency, address untouched
        run_build(9'd500, -1, 9'd0, -1, addr1, first_v, nvalid, nbusy);
        check("oob_addr",   32'(addr1), 32'd59);
        check("oob_lat",    32'(first_v), 32'(LAT));
        check("oob_npulse", 32'(nvalid), 32'd1);
        check_line("oob_data", zero_line);

        // request while busy is dropped
        run_build(9'd29, 10, 9'd0, -1, addr1, first_v, nvalid, nbusy);
        check("busyreq_lat",    32'(first_v), 32'(LAT));
        check("busyreq_npulse", 32'(nvalid), 32'd1);
        check("busyreq_busy",   32'(nbusy), 32'(LAT));
        check_line("busyreq_data", expand(row3));

        // reset in the middle of a build
        run_build(9'd0, -1, 9'd0, 30, addr1, first_v, nvalid, nbusy);
        check("midreset_npulse", 32'(nvalid), 32'd0);
        check_line("midreset_hold", zero_line);

        // fresh request afterwards
        run_build(9'd29, -1, 9'd0, -1, addr1, first_v, nvalid, nbusy);
        check("fresh_addr",   32'(addr1), 32'd3);
        check("fresh_lat",    32'(first_v), 32'(LAT));
        check("fresh_npulse", 32'(nvalid), 32'd1);
        check_line("fresh_data", expand(row3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
